present_cipher_core: RTL and testbench

Parametrised PRESENT block-cipher engine. It encrypts or decrypts one 64-bit block per transaction under an 80- or 128-bit key, with on-the-fly round-key generation. It runs one full round per cycle and uses a valid/ready handshake on both sides. It replaces the fixed encrypt-only, 80-bit, free-running-enable engine in the crypto datapath and sits between the key/plaintext staging registers and the ciphertext output buffer.

---
 rtl/present_cipher_core.sv | 189 ++++++++++++++++++
 tb/tb_present_cipher_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_cipher_core.sv
// PRESENT-64 encrypt/decrypt engine, one round per cycle, 80- or 128-bit key.
// Round keys are generated on the fly. Decrypt first runs the key schedule forward to the last key.
module present_cipher_core #(
  parameter int KEY_SIZE = 80,
  parameter int ROUNDS   = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                decrypt,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic [63:0]         data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         data_out,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : g_bad_key_size
    $error("present_cipher_core: KEY_SIZE must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: ROUNDS must be in 1..31");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_valid is honoured only in IDLE. out_valid holds until out_ready is seen.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYGEN = 3'd1,
    S_ROUND  = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS);
  localparam int         CNT_LO   = (KEY_SIZE == 128) ? 62 : 15;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
      4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
      4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
      4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox4 = 4'h5;  4'h1: inv_sbox4 = 4'hE;  4'h2: inv_sbox4 = 4'hF;  4'h3: inv_sbox4 = 4'h8;
      4'h4: inv_sbox4 = 4'hC;  4'h5: inv_sbox4 = 4'h1;  4'h6: inv_sbox4 = 4'h2;  4'h7: inv_sbox4 = 4'hD;
      4'h8: inv_sbox4 = 4'hB;  4'h9: inv_sbox4 = 4'h4;  4'hA: inv_sbox4 = 4'h6;  4'hB: inv_sbox4 = 4'h3;
      4'hC: inv_sbox4 = 4'h0;  4'hD: inv_sbox4 = 4'h7;  4'hE: inv_sbox4 = 4'h9;  default: inv_sbox4 = 4'hA;
    endcase
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k, input logic [4:0] i);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox4(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = sbox4(r[KEY_SIZE-5 -: 4]);
    r[CNT_LO +: 5] = r[CNT_LO +: 5] ^ i;
    return r;
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k, input logic [4:0] i);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[CNT_LO +: 5] = r[CNT_LO +: 5] ^ i;
    r[KEY_SIZE-1 -: 4] = inv_sbox4(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = inv_sbox4(r[KEY_SIZE-5 -: 4]);
    return {r[60:0], r[KEY_SIZE-1:61]};
  endfunction

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [63:0]         blk_q, blk_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [63:0]         dout_q, dout_d;
  logic                ovalid_q, ovalid_d;

  logic [63:0] rk, rk_mix, enc_s, enc_p, dec_ip, dec_s;

  assign rk     = key_q[KEY_SIZE-1 -: 64];
  assign rk_mix = blk_q ^ rk;

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign enc_s[4*n +: 4] = sbox4(rk_mix[4*n +: 4]);
    assign dec_s[4*n +: 4] = inv_sbox4(dec_ip[4*n +: 4]);
  end

  // Bit j moves to 16*j mod 63; bit 63 stays in place.
  for (genvar j = 0; j < 63; j++) begin : g_perm
    assign enc_p[(16*j) % 63] = enc_s[j];
    assign dec_ip[j]          = rk_mix[(16*j) % 63];
  end
  assign enc_p[63]  = enc_s[63];
  assign dec_ip[63] = rk_mix[63];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = decrypt ? S_KEYGEN : S_ROUND;
      S_KEYGEN: if (cnt_q == LAST_CNT) state_d = S_ROUND;
      S_ROUND:  if (mode_q ? (cnt_q == 5'd1) : (cnt_q == LAST_CNT)) state_d = S_FINAL;
      S_FINAL:  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  always_comb begin
    key_d    = key_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d  = key_in;
          blk_d  = data_in;
          mode_d = decrypt;
          cnt_d  = 5'd1;
        end
      end
      S_KEYGEN: begin
        key_d = key_fwd(key_q, cnt_q);
        cnt_d = (cnt_q == LAST_CNT) ? LAST_CNT : cnt_q + 5'd1;
      end
      S_ROUND: begin
        if (mode_q) begin
          blk_d = dec_s;
          key_d = key_inv(key_q, cnt_q);
          cnt_d = cnt_q - 5'd1;
        end else begin
          blk_d = enc_p;
          key_d = key_fwd(key_q, cnt_q);
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FINAL: begin
        dout_d   = rk_mix;
        ovalid_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) ovalid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      blk_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      blk_q    <= blk_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ovalid_q;

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: three instances (80/31, 128/31, 80/1) behind one
// shared driver, known-answer table, randomized traffic against a PRESENT model, handshake and reset sequences.
module tb_present_cipher_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   sel = 2'd0;
  logic         in_valid = 1'b0;
  logic         decrypt = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] key = '0;
  logic [63:0]  din = '0;

  logic [2:0]  iv_v, or_v, ir_v, ov_v, busy_v;
  logic [63:0] dout_v [3];
  logic [2:0]  dbg_v [3];
  logic        in_ready, out_valid, busy;
  logic [63:0] dout;
  logic [2:0]  dbg;

  always #5 clk = ~clk;

  assign iv_v = {in_valid && sel == 2'd2, in_valid && sel == 2'd1, in_valid && sel == 2'd0};
  assign or_v = {out_ready && sel == 2'd2, out_ready && sel == 2'd1, out_ready && sel == 2'd0};
  assign in_ready  = ir_v[sel];
  assign out_valid = ov_v[sel];
  assign busy      = busy_v[sel];
  assign dout      = dout_v[sel];
  assign dbg       = dbg_v[sel];

  present_cipher_core #(.KEY_SIZE(80), .ROUNDS(31)) u_k80 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir_v[0]), .decrypt(decrypt),
    .key_in(key[79:0]), .data_in(din), .out_valid(ov_v[0]), .out_ready(or_v[0]),
    .data_out(dout_v[0]), .busy(busy_v[0]), .dbg_state(dbg_v[0]));

  present_cipher_core #(.KEY_SIZE(128), .ROUNDS(31)) u_k128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir_v[1]), .decrypt(decrypt),
    .key_in(key), .data_in(din), .out_valid(ov_v[1]), .out_ready(or_v[1]),
    .data_out(dout_v[1]), .busy(busy_v[1]), .dbg_state(dbg_v[1]));

  present_cipher_core #(.KEY_SIZE(80), .ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir_v[2]), .decrypt(decrypt),
    .key_in(key[79:0]), .data_in(din), .out_valid(ov_v[2]), .out_ready(or_v[2]),
    .data_out(dout_v[2]), .busy(busy_v[2]), .dbg_state(dbg_v[2]));

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic int cfg_ks(input logic [1:0] s);
    return (s == 2'd1) ? 128 : 80;
  endfunction

  function automatic int cfg_rounds(input logic [1:0] s);
    return (s == 2'd2) ? 1 : 31;
  endfunction

  function automatic logic [3:0] m_s(input logic [3:0] x, input bit inv);
    if (!inv) return sb[x];
    for (int v = 0; v < 16; v++) if (sb[v] == x) return 4'(v);
    return 4'h0;
  endfunction

  function automatic logic [63:0] m_slayer(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = m_s(x[4*n +: 4], inv);
    return y;
  endfunction

  function automatic logic [63:0] m_player(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    y[63] = x[63];
    for (int j = 0; j < 63; j++) begin
      if (inv) y[j] = x[(16*j) % 63];
      else     y[(16*j) % 63] = x[j];
    end
    return y;
  endfunction

  function automatic logic [63:0] m_present(input bit dec, input int ks, input int rounds,
                                            input logic [127:0] user_key, input logic [63:0] d);
    logic [127:0] k, mask;
    logic [63:0]  rk [33];
    logic [63:0]  s;
    int           pos;
    mask = (ks == 128) ? {128{1'b1}} : {48'h0, {80{1'b1}}};
    pos  = (ks == 128) ? 62 : 15;
    k    = user_key & mask;
    rk[1] = k[ks-1 -: 64];
    for (int i = 1; i <= rounds; i++) begin
      k = ((k << 61) | (k >> (ks - 61))) & mask;
      k[ks-1 -: 4] = m_s(k[ks-1 -: 4], 1'b0);
      if (ks == 128) k[ks-5 -: 4] = m_s(k[ks-5 -: 4], 1'b0);
      k[pos +: 5] = k[pos +: 5] ^ 5'(i);
      rk[i+1] = k[ks-1 -: 64];
    end
    if (!dec) begin
      s = d;
      for (int i = 1; i <= rounds; i++) s = m_player(m_slayer(s ^ rk[i], 1'b0), 1'b0);
      s = s ^ rk[rounds+1];
    end else begin
      s = d ^ rk[rounds+1];
      for (int i = rounds; i >= 1; i--) s = m_slayer(m_player(s, 1'b1), 1'b1) ^ rk[i];
    end
    return s;
  endfunction

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic send(input logic [1:0] s, input logic dec, input logic [127:0] k,
                      input logic [63:0] d, input logic [63:0] exp);
    int guard;
    guard = 0;
    sel = s;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    decrypt  = dec;
    key      = k;
    din      = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic handoff(input logic [63:0] e);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ovalid_cleared", 64'(out_valid), 64'd0);
    check("ready_after_handoff", 64'(in_ready), 64'd1);
    check("dout_held_after_handoff", dout, e);
  endtask

  task automatic collect(input string name, input int exp_lat, input bit noise,
                         input bit consume, output logic [63:0] e);
    int lat;
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        decrypt  = 1'($urandom_range(0, 1));
        key      = {$urandom, $urandom, $urandom, $urandom};
        din      = {$urandom, $urandom};
      end
      @(posedge clk);
      #1 lat++;
      if (lat == 1) begin
        check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
        check({name, "_not_ready_after_accept"}, 64'(in_ready), 64'd0);
      end
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({name, "_data"}, dout, e);
    if (consume) handoff(e);
  endtask

  function automatic int lat_of(input logic [1:0] s, input logic dec);
    return dec ? 2 * cfg_rounds(s) + 1 : cfg_rounds(s) + 1;
  endfunction

  typedef struct {
    logic [1:0]   sel;
    logic         dec;
    logic [127:0] key;
    logic [63:0]  din;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [127:0] k1;
    logic [63:0]  d1, e, r;
    logic [1:0]   s;
    logic         dc;

    k1 = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
    vecs[0] = '{2'd0, 1'b0, 128'h0, 64'h0, 64'h5579C1387B228445};
    vecs[1] = '{2'd0, 1'b0, k1, 64'h0, 64'hE72C46C0F5945049};
    vecs[2] = '{2'd0, 1'b0, 128'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA112FFC72F68417B};
    vecs[3] = '{2'd0, 1'b0, k1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2};
    vecs[4] = '{2'd0, 1'b1, 128'h0, 64'h5579C1387B228445, 64'h0};
    vecs[5] = '{2'd0, 1'b1, k1, 64'hE72C46C0F5945049, 64'h0};
    vecs[6] = '{2'd0, 1'b1, 128'h0, 64'hA112FFC72F68417B, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{2'd0, 1'b1, k1, 64'h3333DCD3213210D2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8] = '{2'd1, 1'b0, 128'h0, 64'h0, 64'h96DB702A2E6900AF};
    vecs[9] = '{2'd1, 1'b1, 128'h0, 64'h96DB702A2E6900AF, 64'h0};

    // clock/reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_data_out", dout, 64'h0);
      check("reset_dbg_idle", 64'(dbg), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // known-answer table
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].sel, vecs[i].dec, vecs[i].key, vecs[i].din, vecs[i].exp);
      collect($sformatf("kat%0d", i), lat_of(vecs[i].sel, vecs[i].dec), 1'b0, 1'b1, e);
    end

    // single-round instance, encrypt then decrypt of the same block
    k1 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom};
    r  = m_present(1'b0, 80, 1, k1, d1);
    send(2'd2, 1'b0, k1, d1, r);
    collect("r1_enc", 2, 1'b0, 1'b1, e);
    send(2'd2, 1'b1, k1, r, d1);
    collect("r1_dec", 3, 1'b0, 1'b1, e);

    // randomized traffic with junk on the inputs while busy
    for (int i = 0; i < 24; i++) begin
      s  = 2'($urandom_range(0, 2));
      dc = 1'($urandom_range(0, 1));
      k1 = {$urandom, $urandom, $urandom, $urandom};
      d1 = {$urandom, $urandom};
      send(s, dc, k1, d1, m_present(dc, cfg_ks(s), cfg_rounds(s), k1, d1));
      collect($sformatf("rnd%0d", i), lat_of(s, dc), 1'b1, 1'b1, e);
    end

    // output stall: result must hold and new requests must be ignored
    k1 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom};
    send(2'd0, 1'b0, k1, d1, m_present(1'b0, 80, 31, k1, d1));
    collect("stall", 32, 1'b0, 1'b0, e);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      decrypt  = 1'($urandom_range(0, 1));
      key      = {$urandom, $urandom, $urandom, $urandom};
      din      = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("stall_data_stable", dout, e);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    handoff(e);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom};
    send(2'd0, 1'b1, k1, d1, m_present(1'b1, 80, 31, k1, d1));
    collect("after_stall", 63, 1'b0, 1'b1, e);

    // reset in the middle of an encrypt
    send(2'd0, 1'b0, 128'h0, 64'h0, 64'h5579C1387B228445);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_data_out", dout, 64'h0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd0, 1'b0, 128'h0, 64'h0, 64'h5579C1387B228445);
    collect("post_reset", 32, 1'b0, 1'b1, e);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
